// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning an N:1 word mux, presenting the winner on a valid/ready port.
// Optional burst ownership (up to MAX_BURST words per grant) is enabled by defining MUX_ARB_BURST_EN.
module mux_rr_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req,
    input  logic [N*W-1:0]         in_data,
    output logic [W-1:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           ack,
    output logic [N-1:0]           grant,
    output logic [$clog2(N)-1:0]   sel,
    output logic                   busy
);
    localparam int SW = $clog2(N);

    generate
        if (N < 2) begin : g_bad_n
            $error("mux_rr_arbiter: N must be at least 2");
        end
        if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
            $error("mux_rr_arbiter: MAX_BURST must be in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] sel_nxt, ptr, ptr_nxt, winner;
    int            idx;

    // Modulo-N increment; N need not be a power of two.
    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] v);
        return (int'(v) == N - 1) ? '0 : v + 1'b1;
    endfunction

    // Scan from the far end back towards ptr so the nearest requester wins.
    always_comb begin
        winner = ptr;
        idx    = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) winner = SW'(idx);
        end
    end

`ifdef MUX_ARB_BURST_EN
    logic [7:0] burst_cnt, burst_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) burst_cnt <= '0;
        else        burst_cnt <= burst_nxt;
    end
`endif

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
`ifdef MUX_ARB_BURST_EN
        burst_nxt = burst_cnt;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    sel_nxt   = winner;
                    state_nxt = GRANT;
`ifdef MUX_ARB_BURST_EN
                    burst_nxt = '0;
`endif
                end
            end
            GRANT: begin
                if (out_ready) begin
`ifdef MUX_ARB_BURST_EN
                    burst_nxt = burst_cnt + 8'd1;
                    state_nxt = HOLD;
`else
                    ptr_nxt   = wrap_inc(sel);
                    state_nxt = IDLE;
`endif
                end else if (!req[sel]) begin
                    // Requester withdrew without a handshake: give up the grant.
                    ptr_nxt   = wrap_inc(sel);
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
`ifdef MUX_ARB_BURST_EN
                if (req[sel] && int'(burst_cnt) < MAX_BURST) begin
                    state_nxt = GRANT;
                end else begin
                    ptr_nxt   = wrap_inc(sel);
                    state_nxt = IDLE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
        end
    end

    assign out_valid = (state == GRANT);
    assign busy      = (state != IDLE);
    assign out_data  = in_data[int'(sel)*W +: W];
    assign ack       = out_ready ? grant : '0;

    always_comb begin
        grant = '0;
        if (out_valid) grant[sel] = 1'b1;
    end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, corner sequences and
// randomized traffic checked against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_mux_rr_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N-1:0]       req;
    logic [N*W-1:0]     in_data;
    logic [W-1:0]       out_data;
    logic               out_valid, out_ready, busy;
    logic [N-1:0]       ack, grant;
    logic [1:0]         sel;

    logic [2:0]         req3, ack3, grant3;
    logic [3*W-1:0]     in_data3;
    logic [W-1:0]       out_data3;
    logic               out_valid3, ready3, busy3;
    logic [1:0]         sel3;

    always #5 clk = ~clk;

    mux_rr_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .ack(ack), .grant(grant),
        .sel(sel), .busy(busy)
    );

    mux_rr_arbiter #(.N(3), .W(W), .MAX_BURST(MB)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .in_data(in_data3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(ready3), .ack(ack3), .grant(grant3),
        .sel(sel3), .busy(busy3)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase 0 idle, 1 offering a word, 2 burst bubble.
    int           m_st, m_sel, m_ptr, m_cnt;
    logic [N-1:0] m_ack;
    int           acc_q[$];

    localparam logic [N*W-1:0] D = {8'h43, 8'h32, 8'h21, 8'h10};

    typedef struct {
        logic [N-1:0] req;
        logic         rdy;
        logic         vld;
        logic [1:0]   sel;
        logic [N-1:0] ack;
        logic [N-1:0] gnt;
        logic [W-1:0] data;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_ack = '0;
    endtask

    task automatic model_check();
        logic [N-1:0] g;
        g = '0;
        if (m_st == 1) g[m_sel] = 1'b1;
        m_ack = out_ready ? g : '0;
        chk("m_valid", 32'(out_valid), 32'(m_st == 1));
        chk("m_grant", 32'(grant), 32'(g));
        chk("m_ack",   32'(ack),   32'(m_ack));
        chk("m_sel",   32'(sel),   32'(m_sel));
        chk("m_busy",  32'(busy),  32'(m_st != 0));
        chk("m_data",  32'(out_data), 32'(in_data[m_sel*W +: W]));
    endtask

    task automatic model_adv();
        if (m_st == 1) begin
            if (out_ready) begin
                m_cnt++;
`ifdef MUX_ARB_BURST_EN
                m_st = 2;
`else
                m_ptr = (m_sel + 1) % N;
                m_st  = 0;
`endif
            end else if (!req[m_sel]) begin
                m_ptr = (m_sel + 1) % N;
                m_st  = 0;
            end
        end else if (m_st == 2) begin
            if (req[m_sel] && m_cnt < MB) m_st = 1;
            else begin
                m_ptr = (m_sel + 1) % N;
                m_st  = 0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (req[(m_ptr + k) % N]) begin
                    m_sel = (m_ptr + k) % N;
                    m_cnt = 0;
                    m_st  = 1;
                    break;
                end
            end
        end
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic rdy);
        req = r; in_data = d; out_ready = rdy;
        #1;
        model_check();
    endtask

    task automatic adv();
        model_adv();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic rdy);
        drive(r, d, rdy);
        adv();
    endtask

    task automatic collect(input logic [N-1:0] r, input int want, input int budget);
        acc_q.delete();
        for (int c = 0; c < budget && acc_q.size() < want; c++) begin
            drive(r, D, 1'b1);
            if (ack != '0) acc_q.push_back($clog2(ack));
            adv();
        end
        if (acc_q.size() < want) chk("collect_timeout", 32'(acc_q.size()), 32'(want));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0]   r;
        logic [N*W-1:0] d;
        int             exp_q[$];

        tbl[0] = '{4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 8'h10};
        tbl[1] = '{4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 4'h1, 8'h10};
        tbl[2] = '{4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 8'h10};
        tbl[3] = '{4'hF, 1'b1, 1'b1, 2'd1, 4'h2, 4'h2, 8'h21};
        tbl[4] = '{4'hF, 1'b1, 1'b0, 2'd1, 4'h0, 4'h0, 8'h21};
        tbl[5] = '{4'hF, 1'b1, 1'b1, 2'd2, 4'h4, 4'h4, 8'h32};
        tbl[6] = '{4'hF, 1'b1, 1'b0, 2'd2, 4'h0, 4'h0, 8'h32};
        tbl[7] = '{4'hF, 1'b1, 1'b1, 2'd3, 4'h8, 4'h8, 8'h43};
        tbl[8] = '{4'hF, 1'b1, 1'b0, 2'd3, 4'h0, 4'h0, 8'h43};
        tbl[9] = '{4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 4'h1, 8'h10};

        rst_n = 1'b0; req = 4'hF; in_data = D; out_ready = 1'b0;
        req3 = '0; in_data3 = {8'hC2, 8'hB1, 8'hA0}; ready3 = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sel",   32'(sel), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_data",  32'(out_data), 32'h10);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef MUX_ARB_BURST_EN
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].req, D, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d_sel", i),   32'(sel),       32'(tbl[i].sel));
            chk($sformatf("tbl%0d_ack", i),   32'(ack),       32'(tbl[i].ack));
            chk($sformatf("tbl%0d_grant", i), 32'(grant),     32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_data", i),  32'(out_data),  32'(tbl[i].data));
            adv();
        end
`else
        collect(4'b0011, 5, 30);
        exp_q = '{0, 0, 1, 1, 0};
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            chk($sformatf("burst_order%0d", i), 32'(acc_q[i]), 32'(exp_q[i]));
        repeat (3) cyc(4'b0000, D, 1'b1);
        cyc(4'b0001, D, 1'b1);
        drive(4'b0001, D, 1'b1);
        chk("burst_drop_ack0", 32'(ack), 32'h1);
        adv();
        drive(4'b0010, D, 1'b1);
        chk("burst_hold_bubble", 32'(out_valid), 32'd0);
        adv();
        collect(4'b0010, 1, 6);
        if (acc_q.size() > 0) chk("burst_drop_next", 32'(acc_q[0]), 32'd1);
        repeat (3) cyc(4'b0000, D, 1'b1);
`endif

        // Backpressure on requester 2.
        cyc(4'b0100, D, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(4'b0100, D, 1'b0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data",  32'(out_data), 32'h32);
            chk("bp_ack",   32'(ack), 32'd0);
            adv();
        end
        drive(4'b0100, D, 1'b1);
        chk("bp_release_ack", 32'(ack), 32'h4);
        adv();
        drive(4'b0000, D, 1'b1);
        chk("bp_after_valid", 32'(out_valid), 32'd0);
        adv();
        repeat (2) cyc(4'b0000, D, 1'b1);

`ifndef MUX_ARB_BURST_EN
        // ptr is now 3: requester 0 wins by wrapping, then 2.
        collect(4'b0101, 2, 10);
        exp_q = '{0, 2};
        for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
            chk($sformatf("wrap_order%0d", i), 32'(acc_q[i]), 32'(exp_q[i]));
        repeat (2) cyc(4'b0000, D, 1'b1);

        // N=3 instance: pointer wraps 2 -> 0.
        req = '0;
        req3 = 3'b111;
        exp_q = '{0, 1, 2, 0};
        acc_q.delete();
        for (int c = 0; c < 12 && acc_q.size() < 4; c++) begin
            #1;
            if (ack3 != '0) begin
                chk($sformatf("n3_data%0d", acc_q.size()), 32'(out_data3),
                    32'(in_data3[exp_q[acc_q.size()]*W +: W]));
                acc_q.push_back(int'(sel3));
            end
            @(posedge clk); @(negedge clk);
        end
        chk("n3_count", 32'(acc_q.size()), 32'd4);
        for (int i = 0; i < acc_q.size(); i++)
            chk($sformatf("n3_sel%0d", i), 32'(acc_q[i]), 32'(exp_q[i]));
        req3 = '0;
        @(posedge clk); @(negedge clk);
`endif

        // Reset asserted while a word is being accepted.
        cyc(4'b0010, D, 1'b1);
        drive(4'b0010, D, 1'b1);
        chk("mid_pre_ack", 32'(ack), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_ack",   32'(ack), 32'd0);
        chk("mid_grant", 32'(grant), 32'd0);
        chk("mid_sel",   32'(sel), 32'd0);
        chk("mid_busy",  32'(busy), 32'd0);
        chk("mid_data",  32'(out_data), 32'h10);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized protocol-legal traffic with occasional withdrawn requests.
        r = '0;
        d = D;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    if (m_ack[i]) begin
                        if ($urandom_range(1, 0) == 1) d[i*W +: W] = W'($urandom);
                        else r[i] = 1'b0;
                    end else if ($urandom_range(40, 0) == 0) begin
                        r[i] = 1'b0;
                    end
                end else if ($urandom_range(2, 0) == 0) begin
                    r[i] = 1'b1;
                    d[i*W +: W] = W'($urandom);
                end
            end
            cyc(r, d, $urandom_range(9, 0) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
